// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester queued writeback arbiter for the 32 x 64 register file
// Round-robin drains one queued write per cycle into the registered write port and tracks pending writes.
module regfile_write_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic [31:0]       busy,
  output logic              idle
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int QC_W  = $clog2(QDEPTH + 1);
  localparam int PC_W  = $clog2(2 * QDEPTH + 2);
  localparam logic [QC_W-1:0]   Q_FULL    = QC_W'(QDEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(QDEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  // Index 0 is requester A, index 1 is requester B.
  logic [ADDR_W-1:0] qAddr [2][QDEPTH];
  logic [DATA_W-1:0] qData [2][QDEPTH];
  logic [PTR_W-1:0]  rdPtr [2];
  logic [PTR_W-1:0]  wrPtr [2];
  logic [QC_W-1:0]   qCount [2];
  logic [PC_W-1:0]   pendCount [32];
  logic [PC_W-1:0]   pendNext [32];
  logic              lastGrantB;

  logic              inValid [2];
  logic [ADDR_W-1:0] inAddr [2];
  logic [DATA_W-1:0] inData [2];
  logic [1:0]        ready, notEmpty, push, pop;
  logic              popSel;
  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData;

  assign inValid[0] = a_valid;
  assign inValid[1] = b_valid;
  assign inAddr[0]  = a_addr;
  assign inAddr[1]  = b_addr;
  assign inData[0]  = a_data;
  assign inData[1]  = b_data;
  assign a_ready    = ready[0];
  assign b_ready    = ready[1];

  always_comb begin
    ready    = '0;
    notEmpty = '0;
    push     = '0;
    pop      = '0;
    for (int r = 0; r < 2; r++) begin
      ready[r]    = qCount[r] != Q_FULL;
      notEmpty[r] = qCount[r] != '0;
      // Writes to the zero register complete the handshake but are never queued.
      push[r]     = inValid[r] & ready[r] & (inAddr[r] != ZERO_ADDR);
    end
    if (notEmpty[0] && (!notEmpty[1] || lastGrantB))
      pop[0] = 1'b1;
    else if (notEmpty[1])
      pop[1] = 1'b1;
  end

  assign popSel   = pop[1];
  assign headAddr = qAddr[popSel][rdPtr[popSel]];
  assign headData = qData[popSel][rdPtr[popSel]];

  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) begin
        qAddr[r][wrPtr[r]] <= inAddr[r];
        qData[r][wrPtr[r]] <= inData[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 2; r++) begin
        rdPtr[r]  <= '0;
        wrPtr[r]  <= '0;
        qCount[r] <= '0;
      end
      lastGrantB    <= 1'b1;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push[r]) wrPtr[r] <= (wrPtr[r] == PTR_LAST) ? '0 : wrPtr[r] + PTR_W'(1);
        if (pop[r])  rdPtr[r] <= (rdPtr[r] == PTR_LAST) ? '0 : rdPtr[r] + PTR_W'(1);
        qCount[r] <= qCount[r] + QC_W'(push[r]) - QC_W'(pop[r]);
      end
      RegWrite <= |pop;
      if (|pop) begin
        lastGrantB    <= pop[1];
        WriteRegister <= headAddr;
        WriteData     <= headData;
      end
    end
  end

  // Enqueues count up, the commit edge of a RegWrite cycle counts down.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      pendNext[i] = pendCount[i];
      if (push[0] && inAddr[0] == ADDR_W'(i)) pendNext[i] = pendNext[i] + PC_W'(1);
      if (push[1] && inAddr[1] == ADDR_W'(i)) pendNext[i] = pendNext[i] + PC_W'(1);
      if (RegWrite && WriteRegister == ADDR_W'(i)) pendNext[i] = pendNext[i] - PC_W'(1);
      if (i == ZERO_REG) pendNext[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) pendCount[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) pendCount[i] <= pendNext[i];
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < 32; i++) busy[i] = pendCount[i] != '0;
  end

  assign idle = !notEmpty[0] && !notEmpty[1] && !RegWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
// Directed steps plus random traffic checked against a queue-based reference model.
module tb_regfile_write_arbiter;

  localparam int QD = 2;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [63:0] a_data, b_data;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [31:0] busy;
  logic        idle;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .busy(busy), .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  ent_t        mqA[$];
  ent_t        mqB[$];
  logic        mRegWrite;
  logic [4:0]  mWReg;
  logic [63:0] mWData;
  logic        mLastB;
  logic [63:0] mRf [32];
  logic [63:0] dutRf [32];
  logic        accA, accB;
  int          cycleNo = 0;
  int          commitLog[$];
  int          commitCyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelBusy();
    logic [31:0] b = '0;
    foreach (mqA[k]) b[mqA[k].addr] = 1'b1;
    foreach (mqB[k]) b[mqB[k].addr] = 1'b1;
    if (mRegWrite) b[mWReg] = 1'b1;
    return b;
  endfunction

  function automatic logic modelIdle();
    return (mqA.size() == 0) && (mqB.size() == 0) && !mRegWrite;
  endfunction

  task automatic modelReset();
    mqA.delete();
    mqB.delete();
    mRegWrite = 1'b0;
    mWReg     = '0;
    mWData    = '0;
    mLastB    = 1'b1;
  endtask

  // One clock: check ready, log the regfile write in progress, advance model, check outputs.
  task automatic cycle();
    ent_t e;
    logic gA, gB;
    chk("a_ready", a_ready, mqA.size() < QD);
    chk("b_ready", b_ready, mqB.size() < QD);
    if (RegWrite) begin
      dutRf[WriteRegister] = WriteData;
      commitLog.push_back(int'(WriteRegister));
      commitCyc.push_back(cycleNo);
    end
    accA = a_valid && (mqA.size() < QD);
    accB = b_valid && (mqB.size() < QD);
    if (mRegWrite) mRf[mWReg] = mWData;
    gA = (mqA.size() != 0) && ((mqB.size() == 0) || mLastB);
    gB = !gA && (mqB.size() != 0);
    mRegWrite = gA || gB;
    if (gA) begin
      e = mqA.pop_front(); mWReg = e.addr; mWData = e.data; mLastB = 1'b0;
    end else if (gB) begin
      e = mqB.pop_front(); mWReg = e.addr; mWData = e.data; mLastB = 1'b1;
    end
    if (accA && a_addr != 5'd31) mqA.push_back('{addr: a_addr, data: a_data});
    if (accB && b_addr != 5'd31) mqB.push_back('{addr: b_addr, data: b_data});
    @(posedge clk);
    @(negedge clk);
    cycleNo++;
    chk("RegWrite", RegWrite, mRegWrite);
    chk("WriteRegister", WriteRegister, mWReg);
    chk("WriteData", WriteData, mWData);
    chk("busy", busy, modelBusy());
    chk("idle", idle, modelIdle());
  endtask

  task automatic quiet();
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    modelReset();
    chk("rst_RegWrite", RegWrite, 1'b0);
    chk("rst_WriteRegister", WriteRegister, 5'd0);
    chk("rst_WriteData", WriteData, 64'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_idle", idle, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic compareRf(input string tag);
    for (int i = 0; i < 32; i++) chk(tag, dutRf[i], mRf[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int aIdx, bIdx;
    int expOrder [8];
    expOrder = '{0, 10, 1, 11, 2, 12, 3, 13};
    for (int i = 0; i < 32; i++) begin
      mRf[i] = '0; dutRf[i] = '0;
    end
    reset = 1'b1;
    quiet();
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    @(negedge clk);
    doReset();
    chk("rst_a_ready", a_ready, 1'b1);
    chk("rst_b_ready", b_ready, 1'b1);

    // Single write from A to X3
    a_valid = 1'b1; a_addr = 5'd3; a_data = 64'h0000010204080001;
    cycle();
    chk("t1_busy3", busy[3], 1'b1);
    quiet();
    cycle();
    chk("t1_wr", RegWrite, 1'b1);
    chk("t1_wreg", WriteRegister, 5'd3);
    chk("t1_wdata", WriteData, 64'h0000010204080001);
    cycle();
    chk("t1_busy3_clr", busy[3], 1'b0);
    chk("t1_idle", idle, 1'b1);

    // Write to the zero register is swallowed
    a_valid = 1'b1; a_addr = 5'd31; a_data = 64'hA0;
    cycle();
    quiet();
    cycle();
    chk("t2_wr", RegWrite, 1'b0);
    chk("t2_busy", busy, 32'd0);
    chk("t2_idle", idle, 1'b1);

    // Same register from both requesters after a fresh reset: A then B
    @(negedge clk);
    doReset();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'd1;
    b_valid = 1'b1; b_addr = 5'd5; b_data = 64'd2;
    cycle();
    chk("t3_busy5", busy[5], 1'b1);
    quiet();
    cycle();
    chk("t3_first", WriteData, 64'd1);
    cycle();
    chk("t3_second", WriteData, 64'd2);
    chk("t3_busy5_held", busy[5], 1'b1);
    cycle();
    chk("t3_busy5_clr", busy[5], 1'b0);
    chk("t3_x5", dutRf[5], 64'd2);

    // Both requesters stream four writes each
    commitLog.delete(); commitCyc.delete();
    aIdx = 0; bIdx = 0;
    for (int n = 0; n < 20 && (aIdx < 4 || bIdx < 4); n++) begin
      a_valid = aIdx < 4; a_addr = 5'(aIdx);      a_data = 64'hAA00 + 64'(aIdx);
      b_valid = bIdx < 4; b_addr = 5'(10 + bIdx); b_data = 64'hBB00 + 64'(bIdx);
      cycle();
      if (accA) aIdx++;
      if (accB) bIdx++;
    end
    quiet();
    repeat (4) cycle();
    chk("t4_count", commitLog.size(), 8);
    if (commitLog.size() == 8) begin
      for (int k = 0; k < 8; k++) chk("t4_order", commitLog[k], expOrder[k]);
      chk("t4_span", commitCyc[7] - commitCyc[0], 7);
    end
    compareRf("t4_rf");

    // Random traffic including zero-register writes and backpressure
    for (int n = 0; n < 300; n++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 3) != 0);
      a_addr  = 5'($urandom_range(0, 31));
      b_addr  = 5'($urandom_range(0, 31));
      a_data  = {$urandom, $urandom};
      b_data  = {$urandom, $urandom};
      cycle();
    end
    quiet();
    repeat (5) cycle();
    compareRf("rand_rf");

    // Reset while writes are queued and one is on the write port
    for (int n = 0; n < 3; n++) begin
      a_valid = 1'b1; a_addr = 5'(20 + n); a_data = 64'hDEAD0000 + 64'(n);
      b_valid = 1'b1; b_addr = 5'(24 + n); b_data = 64'hBEEF0000 + 64'(n);
      cycle();
    end
    quiet();
    chk("t6_wr_before", RegWrite, 1'b1);
    doReset();
    repeat (4) cycle();
    chk("t6_idle", idle, 1'b1);
    compareRf("t6_rf");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32 x 64-bit register file (X31 hard-wired zero) between two writeback requesters: A is the ALU/execute writeback, B is the memory/multi-cycle writeback.
- Each requester has a 2-deep queue. A round-robin arbiter drains one queued write per cycle into registered RegWrite/WriteRegister/WriteData.
- Exports a per-register pending-write mask so hazard/stall logic can hold readers of in-flight registers.

Parameters:
- DATA_W, 64, write data width
- ADDR_W, 5, register address width
- ZERO_REG, 31, hard-wired zero register; writes to it are discarded
- QDEPTH, 2, entries per requester queue

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- a_valid  input  1  requester A has a write
- a_ready  output  1  A queue not full; transfer on a_valid & a_ready at rising edge
- a_addr  input  ADDR_W  A destination register
- a_data  input  DATA_W  A write value
- b_valid  input  1  requester B has a write
- b_ready  output  1  B queue not full
- b_addr  input  ADDR_W  B destination register
- b_data  input  DATA_W  B write value
- RegWrite  output  1  registered write enable to regfile
- WriteRegister  output  ADDR_W  registered write address to regfile
- WriteData  output  DATA_W  registered write data to regfile
- busy  output  32  bit i = 1 while any accepted write to register i has not yet committed
- idle  output  1  both queues empty and RegWrite = 0

Behaviour:
- Reset, asynchronous and immediate:
  - Queues emptied, all pending counters 0.
  - RegWrite = 0, WriteRegister = 0, WriteData = 0, busy = 0, idle = 1.
  - Round-robin pointer set so A wins the first tie.
  - Reset mid-operation drops all queued and in-flight writes; nothing reaches the regfile.
- Ready:
  - x_ready = queue x not full, i.e. count < QDEPTH.
  - Ready does not depend on valid.
  - A full queue that is popped in the same cycle still shows ready = 0 (no pass-through).
- Accept:
  - Transfer happens at an edge with x_valid & x_ready.
  - If x_addr == ZERO_REG, the write is accepted (handshake completes), not enqueued, and leaves busy unchanged.
- Queue order:
  - FIFO within each requester.
  - No ordering guarantee between A and B except the round-robin rule below.
- Arbitration, combinational, from the queue heads at the start of the cycle:
  - Neither queue non-empty: no pop.
  - One queue non-empty: pop it.
  - Both non-empty: pop the requester not granted most recently.
  - The pointer updates only on a pop.
- Output stage:
  - A popped entry is registered at the next edge: RegWrite = 1, WriteRegister and WriteData take the entry's values.
  - No pop: RegWrite = 0; WriteRegister and WriteData hold their last values.
  - The regfile commits at the edge ending a RegWrite = 1 cycle.
- Latency:
  - Accept at edge k into an empty queue that wins arbitration: RegWrite high during cycle k+1 to k+2, committed at edge k+2.
  - Sustained throughput is 1 write per cycle.
- Pending counters, one 3-bit counter per register 0..30:
  - +1 per enqueue to that register; A and B to the same register in the same edge gives +2.
  - -1 at the edge where RegWrite = 1 and WriteRegister == i.
  - Simultaneous enqueue and commit to the same register: net 0.
  - Maximum in flight per register is 2 QDEPTH + 1 = 5, so there is no overflow.
- busy:
  - busy[i] = (count_i != 0); busy[31] = 0 always.
  - A register is busy from the edge after acceptance through the commit edge.
- Same-register write from both requesters: the value from the later grant is the final regfile value.

Test Plan:
- Reset, then a_valid = 1, a_addr = 3, a_data = 64'h0000010204080001 at edge 0 -> a_ready = 1; busy[3] = 1 after edge 0; RegWrite = 1, WriteRegister = 3, WriteData = 64'h0000010204080001 in the cycle after edge 1; busy[3] = 0 and idle = 1 after edge 2.
- a_addr = 31, a_data = 64'hA0 accepted -> RegWrite stays 0, busy = 0, idle remains 1.
- A writes X5 = 1 and B writes X5 = 2 at the same edge -> busy[5] = 1; grants in order A then B on consecutive cycles; busy[5] clears after the second commit; X5 reads 2.
- A and B both stream 4 writes each (A: X0..X3, B: X10..X13) held valid -> outputs alternate A, B, A, B ...; ready drops to 0 when a queue holds 2; all 8 commit in 8 consecutive RegWrite cycles with per-requester order kept.
- B holds 2 entries and b_valid stays 1 -> b_ready = 0 until a pop; no entry lost or duplicated.
- Assert reset while both queues are full and RegWrite = 1 -> RegWrite, busy and queues clear immediately; after release no write to any queued register occurs and idle = 1.
